// File: rtl/parking_exit_gate.sv
// rtl/parking_exit_gate.sv - exit barrier controller: code check, lockout, occupancy and display
// All outputs are registered from the current state; 7-segment patterns are active-low {g,f,e,d,c,b,a}.
module parking_exit_gate #(
   parameter int         CAPACITY    = 20,
   parameter logic [1:0] EXIT_CODE_1 = 2'b10,
   parameter logic [1:0] EXIT_CODE_2 = 2'b01,
   parameter int         WAIT_CYCLES = 50_000_000,
   parameter int         OPEN_CYCLES = 250_000_000,
   parameter int         LOCK_CYCLES = 500_000_000,
   parameter int         MAX_TRIES   = 3,
   parameter int         BLINK_BIT   = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sensor_exit,
   input  logic       sensor_clear,
   input  logic       code_valid,
   input  logic [1:0] exit_code_1,
   input  logic [1:0] exit_code_2,
   input  logic       car_entered,
   output logic       gate_open,
   output logic       lot_full,
   output logic [6:0] occupancy,
   output logic       GREEN_LED,
   output logic       RED_LED,
   output logic [6:0] HEX_1,
   output logic [6:0] HEX_2
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_CODE  = 3'd1;
   localparam logic [2:0] S_WRONG_CODE = 3'd2;
   localparam logic [2:0] S_OPEN       = 3'd3;
   localparam logic [2:0] S_LOCKOUT    = 3'd4;

   localparam int TW  = 32;
   localparam int TRW = $clog2(MAX_TRIES + 1);

   localparam logic [TW-1:0]  WAIT_LIM  = TW'(WAIT_CYCLES - 1);
   localparam logic [TW-1:0]  OPEN_LIM  = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0]  LOCK_LIM  = TW'(LOCK_CYCLES - 1);
   localparam logic [TRW-1:0] TRIES_MAX = TRW'(MAX_TRIES);
   localparam logic [6:0]     CAP7      = 7'(CAPACITY);

   localparam logic [6:0] SEG_E    = 7'b0000110;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_L    = 7'b1000111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   function automatic logic [6:0] seg7(input logic [3:0] digit);
      case (digit)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_OFF;
      endcase
   endfunction

   logic [2:0]         state_q, state_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [TRW-1:0]     tries_q, tries_d;
   logic [6:0]         occ_q, occ_d;
   logic               lot_full_q, lot_full_d;
   logic               clear_prev_q, clear_prev_d;
   logic [BLINK_BIT:0] blink_q, blink_d;
   logic               gate_q, gate_d;
   logic               green_q, green_d;
   logic               red_q, red_d;
   logic [6:0]         hex1_q, hex1_d;
   logic [6:0]         hex2_q, hex2_d;

   logic               code_match;
   logic               clear_rise;
   logic               exit_event;
   logic [TRW-1:0]     tries_inc;
   logic [TW-1:0]      timer_limit;
   logic [6:0]         free_cnt;

   always_comb begin
      code_match  = code_valid && (exit_code_1 == EXIT_CODE_1) && (exit_code_2 == EXIT_CODE_2);
      clear_rise  = sensor_clear && !clear_prev_q;
      // tries only needs to distinguish "reached MAX_TRIES", so it parks there
      tries_inc   = (tries_q >= TRIES_MAX) ? tries_q : tries_q + TRW'(1);
      state_d     = state_q;
      tries_d     = tries_q;
      exit_event  = 1'b0;
      timer_limit = '1;

      case (state_q)
         S_IDLE: begin
            if (sensor_exit && (occ_q != 7'd0)) state_d = S_WAIT_CODE;
         end
         S_WAIT_CODE: begin
            timer_limit = WAIT_LIM;
            if (!sensor_exit) begin
               state_d = S_IDLE;
            end else if (code_valid) begin
               if (code_match) begin
                  state_d = S_OPEN;
               end else begin
                  tries_d = tries_inc;
                  state_d = S_WRONG_CODE;
               end
            end else if (timer_q == WAIT_LIM) begin
               state_d = S_IDLE;
            end
         end
         S_WRONG_CODE: begin
            if (!sensor_exit) begin
               state_d = S_IDLE;
            end else if (code_valid) begin
               if (code_match) begin
                  state_d = S_OPEN;
               end else begin
                  tries_d = tries_inc;
                  if (tries_inc >= TRIES_MAX) state_d = S_LOCKOUT;
               end
            end
         end
         S_OPEN: begin
            timer_limit = OPEN_LIM;
            if (clear_rise) begin
               exit_event = 1'b1;
               tries_d    = '0;
               state_d    = S_IDLE;
            end else if (timer_q == OPEN_LIM) begin
               state_d = S_IDLE;
            end
         end
         S_LOCKOUT: begin
            timer_limit = LOCK_LIM;
            if (timer_q == LOCK_LIM) begin
               tries_d = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q)          timer_d = '0;
      else if (timer_q >= timer_limit) timer_d = timer_limit;
      else                             timer_d = timer_q + TW'(1);

      occ_d = occ_q;
      if (car_entered && !exit_event)      occ_d = (occ_q >= CAP7) ? CAP7 : occ_q + 7'd1;
      else if (exit_event && !car_entered) occ_d = (occ_q == 7'd0) ? 7'd0 : occ_q - 7'd1;
      lot_full_d   = (occ_d == CAP7);
      clear_prev_d = sensor_clear;
      blink_d      = blink_q + (BLINK_BIT+1)'(1);
   end

   always_comb begin
      free_cnt = CAP7 - occ_q;
      gate_d   = (state_q == S_OPEN);
      green_d  = (state_q == S_OPEN);
      red_d    = 1'b0;
      hex1_d   = SEG_OFF;
      hex2_d   = SEG_OFF;
      case (state_q)
         S_IDLE: begin
            hex1_d = seg7(4'(free_cnt / 7'd10));
            hex2_d = seg7(4'(free_cnt % 7'd10));
         end
         S_WAIT_CODE: begin
            red_d  = 1'b1;
            hex1_d = SEG_E;
            hex2_d = SEG_DASH;
         end
         S_WRONG_CODE: begin
            red_d  = blink_q[BLINK_BIT];
            hex1_d = SEG_E;
            hex2_d = SEG_E;
         end
         S_OPEN: begin
            hex1_d = seg7(4'd6);
            hex2_d = seg7(4'd0);
         end
         S_LOCKOUT: begin
            red_d  = blink_q[BLINK_BIT];
            hex1_d = SEG_L;
            hex2_d = seg7(4'd0);
         end
         default: begin
            hex1_d = SEG_OFF;
            hex2_d = SEG_OFF;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         tries_q      <= '0;
         occ_q        <= '0;
         lot_full_q   <= 1'b0;
         clear_prev_q <= 1'b0;
         blink_q      <= '0;
         gate_q       <= 1'b0;
         green_q      <= 1'b0;
         red_q        <= 1'b0;
         hex1_q       <= SEG_OFF;
         hex2_q       <= SEG_OFF;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         tries_q      <= tries_d;
         occ_q        <= occ_d;
         lot_full_q   <= lot_full_d;
         clear_prev_q <= clear_prev_d;
         blink_q      <= blink_d;
         gate_q       <= gate_d;
         green_q      <= green_d;
         red_q        <= red_d;
         hex1_q       <= hex1_d;
         hex2_q       <= hex2_d;
      end
   end

   assign gate_open = gate_q;
   assign lot_full  = lot_full_q;
   assign occupancy = occ_q;
   assign GREEN_LED = green_q;
   assign RED_LED   = red_q;
   assign HEX_1     = hex1_q;
   assign HEX_2     = hex2_q;

endmodule

// File: tb/tb_parking_exit_gate.sv
// tb/tb_parking_exit_gate.sv - scenario tasks plus randomized run against a behavioural model
module tb_parking_exit_gate;

   localparam int CAP   = 20;
   localparam int WAITC = 8;
   localparam int OPENC = 12;
   localparam int LOCKC = 10;
   localparam int TRIES = 3;
   localparam int BB    = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sensor_exit = 1'b0;
   logic       sensor_clear = 1'b0;
   logic       code_valid = 1'b0;
   logic [1:0] exit_code_1 = 2'b00;
   logic [1:0] exit_code_2 = 2'b00;
   logic       car_entered = 1'b0;
   logic       gate_open, lot_full, GREEN_LED, RED_LED;
   logic [6:0] occupancy, HEX_1, HEX_2;

   parking_exit_gate #(
      .CAPACITY(CAP), .EXIT_CODE_1(2'b10), .EXIT_CODE_2(2'b01),
      .WAIT_CYCLES(WAITC), .OPEN_CYCLES(OPENC), .LOCK_CYCLES(LOCKC),
      .MAX_TRIES(TRIES), .BLINK_BIT(BB)
   ) dut (
      .clk(clk), .reset(reset), .sensor_exit(sensor_exit), .sensor_clear(sensor_clear),
      .code_valid(code_valid), .exit_code_1(exit_code_1), .exit_code_2(exit_code_2),
      .car_entered(car_entered), .gate_open(gate_open), .lot_full(lot_full),
      .occupancy(occupancy), .GREEN_LED(GREEN_LED), .RED_LED(RED_LED),
      .HEX_1(HEX_1), .HEX_2(HEX_2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef enum int {M_IDLE, M_WAIT, M_WRONG, M_OPEN, M_LOCK} mstate_t;
   mstate_t    m_state = M_IDLE;
   int         m_cycles = 0;
   int         m_tries = 0;
   int         m_occ = 0;
   int         m_blink = 0;
   logic       m_prev_clear = 1'b0;
   logic       e_gate = 1'b0, e_full = 1'b0, e_green = 1'b0, e_red = 1'b0;
   logic [6:0] e_hex1 = 7'h7f, e_hex2 = 7'h7f;
   int         e_occ = 0;

   function automatic logic [6:0] seg7(input int d);
      case (d)
         0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
         3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   localparam logic [6:0] P_E = 7'b0000110;
   localparam logic [6:0] P_DASH = 7'b0111111;
   localparam logic [6:0] P_L = 7'b1000111;

   // One clock edge of the reference: outputs show the state held before the edge.
   function automatic void model_step();
      mstate_t nxt;
      logic    good, rise, left;
      if (reset) begin
         m_state = M_IDLE; m_cycles = 0; m_tries = 0; m_occ = 0; m_blink = 0; m_prev_clear = 1'b0;
         e_gate = 0; e_full = 0; e_green = 0; e_red = 0; e_occ = 0; e_hex1 = 7'h7f; e_hex2 = 7'h7f;
         return;
      end
      e_gate  = (m_state == M_OPEN);
      e_green = (m_state == M_OPEN);
      e_red   = (m_state == M_WAIT) ||
                ((m_state == M_WRONG || m_state == M_LOCK) && (((m_blink >> BB) & 1) == 1));
      case (m_state)
         M_IDLE:  begin e_hex1 = seg7((CAP - m_occ) / 10); e_hex2 = seg7((CAP - m_occ) % 10); end
         M_WAIT:  begin e_hex1 = P_E;     e_hex2 = P_DASH;  end
         M_WRONG: begin e_hex1 = P_E;     e_hex2 = P_E;     end
         M_OPEN:  begin e_hex1 = seg7(6); e_hex2 = seg7(0); end
         default: begin e_hex1 = P_L;     e_hex2 = seg7(0); end
      endcase
      m_blink++;

      good = code_valid && exit_code_1 == 2'b10 && exit_code_2 == 2'b01;
      rise = sensor_clear && !m_prev_clear;
      m_prev_clear = sensor_clear;
      left = 1'b0;
      nxt = m_state;
      case (m_state)
         M_IDLE: if (sensor_exit && m_occ > 0) nxt = M_WAIT;
         M_WAIT: begin
            if (!sensor_exit) nxt = M_IDLE;
            else if (code_valid) begin
               if (good) nxt = M_OPEN;
               else begin m_tries++; nxt = M_WRONG; end
            end else if (m_cycles == WAITC - 1) nxt = M_IDLE;
         end
         M_WRONG: begin
            if (!sensor_exit) nxt = M_IDLE;
            else if (code_valid) begin
               if (good) nxt = M_OPEN;
               else begin m_tries++; if (m_tries >= TRIES) nxt = M_LOCK; end
            end
         end
         M_OPEN: begin
            if (rise) begin left = 1'b1; m_tries = 0; nxt = M_IDLE; end
            else if (m_cycles == OPENC - 1) nxt = M_IDLE;
         end
         default: if (m_cycles == LOCKC - 1) begin m_tries = 0; nxt = M_IDLE; end
      endcase
      if (car_entered && !left && m_occ < CAP) m_occ++;
      if (left && !car_entered && m_occ > 0) m_occ--;
      m_cycles = (nxt != m_state) ? 0 : m_cycles + 1;
      m_state  = nxt;
      e_occ    = m_occ;
      e_full   = (m_occ == CAP);
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1; sensor_exit = 0; sensor_clear = 0; code_valid = 0; car_entered = 0;
      tick();
      reset = 1'b0;
   endtask

   task automatic send_code(input logic [1:0] c1, input logic [1:0] c2);
      code_valid = 1'b1; exit_code_1 = c1; exit_code_2 = c2;
      tick();
      code_valid = 1'b0;
   endtask

   task automatic test_reset();
      pulse_reset();
      checks++;
      if ({gate_open, lot_full, GREEN_LED, RED_LED} !== 4'b0000 || occupancy !== 7'd0) begin
         errors++;
         $display("FAIL reset_outputs got gate/full/grn/red=%b occ=%0d exp 0000 occ=0",
                  {gate_open, lot_full, GREEN_LED, RED_LED}, occupancy);
      end
      checks++;
      if (HEX_1 !== 7'h7f || HEX_2 !== 7'h7f) begin
         errors++;
         $display("FAIL reset_hex got %b %b exp 1111111 1111111", HEX_1, HEX_2);
      end
      tick();
      checks++;
      if (HEX_1 !== seg7(2) || HEX_2 !== seg7(0)) begin
         errors++;
         $display("FAIL idle_free_20 got %b %b exp %b %b", HEX_1, HEX_2, seg7(2), seg7(0));
      end
   endtask

   task automatic test_exit_flow();
      repeat (3) begin car_entered = 1'b1; tick(); car_entered = 1'b0; tick(); end
      checks++;
      if (occupancy !== 7'd3) begin
         errors++; $display("FAIL three_entries got %0d exp 3", occupancy);
      end
      sensor_exit = 1'b1;
      tick();
      send_code(2'b10, 2'b01);
      checks++;
      if (RED_LED !== 1'b1 || HEX_1 !== P_E || HEX_2 !== P_DASH) begin
         errors++; $display("FAIL wait_display got red=%b %b %b exp 1 %b %b", RED_LED, HEX_1, HEX_2, P_E, P_DASH);
      end
      tick();
      checks++;
      if (gate_open !== 1'b1 || GREEN_LED !== 1'b1 || HEX_1 !== seg7(6) || HEX_2 !== seg7(0)) begin
         errors++; $display("FAIL open_state got gate=%b grn=%b %b %b exp 1 1 %b %b",
                            gate_open, GREEN_LED, HEX_1, HEX_2, seg7(6), seg7(0));
      end
      sensor_clear = 1'b1; sensor_exit = 1'b0;
      tick();
      checks++;
      if (occupancy !== 7'd2) begin
         errors++; $display("FAIL exit_decrement got %0d exp 2", occupancy);
      end
      tick();
      sensor_clear = 1'b0;
      checks++;
      if (gate_open !== 1'b0 || HEX_1 !== seg7(1) || HEX_2 !== seg7(8)) begin
         errors++; $display("FAIL idle_after_exit got gate=%b %b %b exp 0 %b %b", gate_open, HEX_1, HEX_2, seg7(1), seg7(8));
      end
   endtask

   task automatic test_lockout();
      int idle_at = -1;
      sensor_exit = 1'b1;
      tick();
      send_code(2'b00, 2'b00);
      tick();
      checks++;
      if (HEX_1 !== P_E || HEX_2 !== P_E) begin
         errors++; $display("FAIL wrong_display got %b %b exp %b %b", HEX_1, HEX_2, P_E, P_E);
      end
      send_code(2'b00, 2'b00);
      tick();
      send_code(2'b00, 2'b00);
      sensor_exit = 1'b0;
      for (int i = 1; i <= 3 * LOCKC; i++) begin
         if (i == 3) begin code_valid = 1'b1; exit_code_1 = 2'b10; exit_code_2 = 2'b01; end
         tick();
         code_valid = 1'b0;
         if (i == 4) begin
            checks++;
            if (gate_open !== 1'b0 || HEX_1 !== P_L || HEX_2 !== seg7(0)) begin
               errors++; $display("FAIL lockout_ignores_code got gate=%b %b %b exp 0 %b %b", gate_open, HEX_1, HEX_2, P_L, seg7(0));
            end
         end
         if (HEX_1 === seg7(1) && HEX_2 === seg7(8)) begin idle_at = i; break; end
      end
      checks++;
      if (idle_at != LOCKC + 1) begin
         errors++; $display("FAIL lockout_duration got %0d exp %0d", idle_at, LOCKC + 1);
      end
   endtask

   task automatic test_wait_timeout();
      int idle_at = -1;
      logic opened = 1'b0;
      sensor_exit = 1'b1;
      tick();
      for (int i = 1; i <= 3 * WAITC; i++) begin
         tick();
         if (gate_open) opened = 1'b1;
         if (HEX_1 === seg7(1) && HEX_2 === seg7(8)) begin idle_at = i; break; end
      end
      checks++;
      if (idle_at != WAITC + 1 || opened !== 1'b0) begin
         errors++; $display("FAIL wait_timeout got idle_at=%0d opened=%b exp %0d 0", idle_at, opened, WAITC + 1);
      end
      sensor_exit = 1'b0;
      tick(); tick();
   endtask

   task automatic test_open_timeout();
      int closed_at = -1;
      sensor_exit = 1'b1;
      tick();
      send_code(2'b10, 2'b01);
      sensor_exit = 1'b0;
      for (int i = 1; i <= 3 * OPENC; i++) begin
         tick();
         if (gate_open === 1'b0) begin closed_at = i; break; end
      end
      checks++;
      if (closed_at != OPENC + 1) begin
         errors++; $display("FAIL open_timeout got %0d exp %0d", closed_at, OPENC + 1);
      end
      checks++;
      if (occupancy !== 7'd2) begin
         errors++; $display("FAIL reversed_car_occ got %0d exp 2", occupancy);
      end
   endtask

   task automatic test_capacity();
      car_entered = 1'b1;
      repeat (CAP + 2) tick();
      car_entered = 1'b0;
      tick();
      checks++;
      if (occupancy !== 7'(CAP) || lot_full !== 1'b1 || HEX_1 !== seg7(0) || HEX_2 !== seg7(0)) begin
         errors++; $display("FAIL full_lot got occ=%0d full=%b %b %b exp %0d 1 %b %b",
                            occupancy, lot_full, HEX_1, HEX_2, CAP, seg7(0), seg7(0));
      end
      sensor_exit = 1'b1;
      tick();
      send_code(2'b10, 2'b01);
      sensor_exit = 1'b0;
      tick();
      sensor_clear = 1'b1; car_entered = 1'b1;
      tick();
      car_entered = 1'b0;
      checks++;
      if (occupancy !== 7'(CAP) || lot_full !== 1'b1) begin
         errors++; $display("FAIL enter_and_exit got occ=%0d full=%b exp %0d 1", occupancy, lot_full, CAP);
      end
      tick();
      sensor_clear = 1'b0;
      checks++;
      if (gate_open !== 1'b0 || HEX_1 !== seg7(0) || HEX_2 !== seg7(0)) begin
         errors++; $display("FAIL full_idle got gate=%b %b %b exp 0 %b %b", gate_open, HEX_1, HEX_2, seg7(0), seg7(0));
      end
   endtask

   task automatic test_reset_in_open();
      sensor_exit = 1'b1;
      tick();
      send_code(2'b10, 2'b01);
      sensor_exit = 1'b0;
      tick();
      checks++;
      if (gate_open !== 1'b1) begin
         errors++; $display("FAIL open_before_reset got %b exp 1", gate_open);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (gate_open !== 1'b0 || occupancy !== 7'd0 || lot_full !== 1'b0 || HEX_1 !== 7'h7f) begin
         errors++; $display("FAIL reset_in_open got gate=%b occ=%0d full=%b hex1=%b exp 0 0 0 1111111",
                            gate_open, occupancy, lot_full, HEX_1);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (HEX_1 !== seg7(2) || HEX_2 !== seg7(0) || gate_open !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset got %b %b gate=%b exp %b %b 0", HEX_1, HEX_2, gate_open, seg7(2), seg7(0));
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 4000 && errors < 30; n++) begin
         reset        = ($urandom_range(0, 399) == 0);
         sensor_exit  = ($urandom_range(0, 9) != 0);
         car_entered  = ($urandom_range(0, 6) == 0);
         code_valid   = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 1) == 1) begin exit_code_1 = 2'b10; exit_code_2 = 2'b01; end
         else begin exit_code_1 = 2'($urandom); exit_code_2 = 2'($urandom); end
         if ($urandom_range(0, 7) == 0) sensor_clear = ~sensor_clear;
         tick();
         checks++;
         if ({gate_open, lot_full, GREEN_LED, RED_LED} !== {e_gate, e_full, e_green, e_red}) begin
            errors++; $display("FAIL rand_flags cyc %0d got %b exp %b", n,
                               {gate_open, lot_full, GREEN_LED, RED_LED}, {e_gate, e_full, e_green, e_red});
         end
         checks++;
         if (occupancy !== 7'(e_occ)) begin
            errors++; $display("FAIL rand_occ cyc %0d got %0d exp %0d", n, occupancy, e_occ);
         end
         checks++;
         if (HEX_1 !== e_hex1 || HEX_2 !== e_hex2) begin
            errors++; $display("FAIL rand_hex cyc %0d got %b %b exp %b %b", n, HEX_1, HEX_2, e_hex1, e_hex2);
         end
      end
      reset = 1'b0; code_valid = 1'b0; car_entered = 1'b0;
   endtask

   initial begin
      test_reset();
      test_exit_flow();
      test_lockout();
      test_wait_timeout();
      test_open_timeout();
      test_capacity();
      test_reset_in_open();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
